tournament_branch_predictor: RTL and testbench
==============================================

// Module: tournament_branch_predictor
// PURPOSE
//   Parametrised tournament predictor: gshare + bimodal tables with a per-PC chooser.
//   Separate predict (fetch) and update (execute/resolve) ports. Speculative global-history
//   register (GHR) is repaired on mispredict. Tables are initialised by a post-reset sweep FSM.
//   Sits in IF beside PC generation; resolution arrives from EX.
// PARAMETERS
//   IDX_BITS  9  log2 entries per table (gshare, bimodal and chooser each hold 2^IDX_BITS entries)
//   GHR_BITS  9  global history length; legal range is 1..IDX_BITS
//   CTR_BITS  2  width of the gshare/bimodal saturating counters (>=2); chooser is always 2 bits
// PORTS
//   clk             in   1         clock, rising edge
//   reset_n         in   1         asynchronous, active-low reset
//   mode            in   2         00 tournament, 01 gshare only, 10 bimodal only, 11 static not-taken
//   pred_valid      in   1         prediction request
//   pred_pc         in   32        PC of the requesting branch
//   pred_ready      out  1         high when requests are accepted (RUN state)
//   pred_out_valid  out  1         one-cycle pulse; result fields below are valid
//   pred_taken      out  1         predicted direction
//   pred_src        out  1         1 = gshare was used, 0 = bimodal/static
//   pred_ghr        out  GHR_BITS  GHR snapshot used for this prediction; carried down the pipe
//   upd_valid       in   1         resolved branch
//   upd_pc          in   32        PC of the resolved branch
//   upd_ghr         in   GHR_BITS  pred_ghr returned with the branch
//   upd_taken       in   1         actual direction
//   upd_mispredict  in   1         prediction was wrong; repair the GHR
//   init_done       out  1         table sweep complete
// BEHAVIOUR
//   Indexing: pidx = pc[IDX_BITS+1:2]; gidx = pidx ^ zero-extend(ghr). Counter "taken" = MSB.
//   Reset (reset_n=0, takes effect immediately, including mid-operation):
//     - all outputs are 0; ghr = 0; FSM = INIT; sweep pointer = 0.
//     - Table contents are not reset directly; the INIT sweep rewrites them.
//   INIT: each cycle writes entry [ptr] in all three tables, then ptr++.
//     - gshare/bimodal entries get 2^(CTR_BITS-1)-1 (weak not-taken); chooser entries get 2'b01 (weak bimodal).
//     - After 2^IDX_BITS cycles: FSM = RUN, init_done = 1, pred_ready = 1.
//     - pred_valid and upd_valid are ignored during INIT.
//   RUN, predict (1-cycle latency):
//     - Request accepted at edge N (pred_valid && pred_ready) -> pred_out_valid = 1 after edge N+1, for exactly one cycle.
//     - Tables are read as they stand before edge N's update write; there is no write-through.
//     - mode 00: chooser MSB selects gshare (1) or bimodal (0). mode 01 forces gshare; 10 forces bimodal.
//     - mode 11: pred_taken = 0, pred_src = 0.
//     - pred_ghr = ghr before the shift. On acceptance: ghr <= {ghr[GHR_BITS-2:0], pred_taken}.
//   RUN, update (takes effect at the accepting edge):
//     - gshare[pidx(upd_pc) ^ upd_ghr] and bimodal[pidx(upd_pc)]: saturating +1 if upd_taken, else saturating -1.
//       Counters stick at 0 and at 2^CTR_BITS-1.
//     - Chooser[pidx(upd_pc)] changes only when the gshare and bimodal MSBs (pre-update) differ:
//       saturating +1 if gshare was correct, saturating -1 if bimodal was correct.
//     - Tables train in every mode.
//     - upd_mispredict: ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This overrides a same-edge speculative shift;
//       that same-edge prediction is still issued, with its pre-shift pred_ghr.
//   GHR_BITS = 1: the shift degenerates to ghr <= taken bit.
//   Predict and update are fully independent ports; both may fire every cycle.
// TESTING (bench uses IDX_BITS=4, GHR_BITS=4, CTR_BITS=2)
//   1. Release reset -> init_done/pred_ready low 16 cycles, rise at cycle 16; first pred_taken=0, pred_src=0.
//   2. 3x update pc=0x40 taken, ghr=0 -> bimodal[0] saturates at 3; later predict pc=0x40 mode 10 -> taken=1.
//   3. Alternating T/N branch at pc=0x80, mode 00, 40 iterations with ghr repair -> chooser[0] reaches 3;
//      last 8 predictions all correct.
//   4. Predict pc=0x10 at ghr=4'b0101 -> pred_ghr=0101, ghr=1011 if taken.
//      Same-edge upd_mispredict, upd_ghr=0011, taken=1 -> ghr=0111.
//   5. Counter at 0, update not-taken -> stays 0. Counter at 3, update taken -> stays 3.
//      Chooser unchanged when both tables agree.
//   6. reset_n low mid-run with pred_out_valid=1 -> outputs 0 asynchronously; INIT restarts; tables re-swept to 1/1/01.

Source files
------------

// File: rtl/tournament_branch_predictor_if.sv
// rtl/tournament_branch_predictor_if.sv - predict/update handshake bundle for the tournament predictor
interface tournament_branch_predictor_if #(
  parameter int GHR_BITS = 9
);
  logic                pred_valid;
  logic [31:0]         pred_pc;
  logic                pred_ready;
  logic                pred_out_valid;
  logic                pred_taken;
  logic                pred_src;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_taken;
  logic                upd_mispredict;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  pred_ready, pred_out_valid, pred_taken, pred_src, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output pred_ready, pred_out_valid, pred_taken, pred_src, pred_ghr
  );
endinterface

// File: rtl/tournament_branch_predictor.sv
// rtl/tournament_branch_predictor.sv - gshare/bimodal tournament predictor with per-PC chooser
// Tables are swept to weak defaults after reset; GHR is speculative and repaired on mispredict.
module tournament_branch_predictor #(
  parameter int IDX_BITS = 9,
  parameter int GHR_BITS = 9,
  parameter int CTR_BITS = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [1:0]                          mode,
  output logic                                init_done,
  tournament_branch_predictor_if.slave        bus
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_BITS-1:0] ptr;
  logic [GHR_BITS-1:0] ghr;

  logic [CTR_BITS-1:0] gsh_tbl [ENTRIES];
  logic [CTR_BITS-1:0] bim_tbl [ENTRIES];
  logic [1:0]          cho_tbl [ENTRIES];

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [1:0] cho_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 1'b1;
    return (c == 2'b00) ? c : c - 1'b1;
  endfunction

  // Truncating the concatenation also covers GHR_BITS == 1, where the history is just the new bit.
  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] h, input logic t);
    return GHR_BITS'({h, t});
  endfunction

  logic running;
  logic pred_fire;
  logic upd_fire;

  assign running        = (state == RUN);
  assign init_done      = running;
  assign bus.pred_ready = running;
  assign pred_fire      = bus.pred_valid && running;
  assign upd_fire       = bus.upd_valid && running;

  logic [IDX_BITS-1:0] p_idx;
  logic [IDX_BITS-1:0] p_gidx;
  logic [IDX_BITS-1:0] u_idx;
  logic [IDX_BITS-1:0] u_gidx;
  logic                unused_pc_bits;

  assign p_idx  = bus.pred_pc[IDX_BITS+1:2];
  assign p_gidx = p_idx ^ IDX_BITS'(ghr);
  assign u_idx  = bus.upd_pc[IDX_BITS+1:2];
  assign u_gidx = u_idx ^ IDX_BITS'(bus.upd_ghr);
  assign unused_pc_bits = ^{bus.pred_pc[31:IDX_BITS+2], bus.pred_pc[1:0],
                            bus.upd_pc[31:IDX_BITS+2], bus.upd_pc[1:0]};

  logic p_gsh;
  logic p_bim;
  logic p_cho;
  logic p_taken;
  logic p_src;

  assign p_gsh = gsh_tbl[p_gidx][CTR_BITS-1];
  assign p_bim = bim_tbl[p_idx][CTR_BITS-1];
  assign p_cho = cho_tbl[p_idx][1];

  always_comb begin
    p_taken = 1'b0;
    p_src   = 1'b0;
    case (mode)
      2'b00: begin
        p_src   = p_cho;
        p_taken = p_cho ? p_gsh : p_bim;
      end
      2'b01: begin
        p_src   = 1'b1;
        p_taken = p_gsh;
      end
      2'b10:   p_taken = p_bim;
      default: ;
    endcase
  end

  logic [CTR_BITS-1:0] u_gsh;
  logic [CTR_BITS-1:0] u_bim;
  logic [1:0]          u_cho;
  logic [CTR_BITS-1:0] u_gsh_new;
  logic [CTR_BITS-1:0] u_bim_new;
  logic [1:0]          u_cho_new;

  assign u_gsh = gsh_tbl[u_gidx];
  assign u_bim = bim_tbl[u_idx];
  assign u_cho = cho_tbl[u_idx];

  // Chooser only learns from branches where the two components disagreed.
  always_comb begin
    u_gsh_new = ctr_step(u_gsh, bus.upd_taken);
    u_bim_new = ctr_step(u_bim, bus.upd_taken);
    u_cho_new = u_cho;
    if (u_gsh[CTR_BITS-1] != u_bim[CTR_BITS-1])
      u_cho_new = cho_step(u_cho, u_gsh[CTR_BITS-1] == bus.upd_taken);
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      gsh_tbl[ptr] <= CTR_INIT;
      bim_tbl[ptr] <= CTR_INIT;
      cho_tbl[ptr] <= 2'b01;
    end else if (upd_fire) begin
      gsh_tbl[u_gidx] <= u_gsh_new;
      bim_tbl[u_idx]  <= u_bim_new;
      cho_tbl[u_idx]  <= u_cho_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (ptr == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // A resolved mispredict rebuilds history from the branch's own snapshot, beating any same-edge shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr                <= '0;
      bus.pred_out_valid <= 1'b0;
      bus.pred_taken     <= 1'b0;
      bus.pred_src       <= 1'b0;
      bus.pred_ghr       <= '0;
    end else begin
      bus.pred_out_valid <= pred_fire;
      if (pred_fire) begin
        bus.pred_taken <= p_taken;
        bus.pred_src   <= p_src;
        bus.pred_ghr   <= ghr;
      end
      if (upd_fire && bus.upd_mispredict)
        ghr <= ghr_shift(bus.upd_ghr, bus.upd_taken);
      else if (pred_fire)
        ghr <= ghr_shift(ghr, p_taken);
    end
  end
endmodule

// File: tb/tb_tournament_branch_predictor.sv
// tb/tb_tournament_branch_predictor.sv - directed self-checking bench for tournament_branch_predictor
module tb_tournament_branch_predictor;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       init_done;
  int         total = 0;
  int         bad = 0;

  tournament_branch_predictor_if #(.GHR_BITS(4)) bus ();

  tournament_branch_predictor #(
    .IDX_BITS(4),
    .GHR_BITS(4),
    .CTR_BITS(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .init_done(init_done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.pred_valid     = 1'b0;
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic drive_pred(input logic [31:0] pc, input logic [1:0] m);
    bus.pred_valid = 1'b1;
    bus.pred_pc    = pc;
    mode           = m;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [3:0] g, input logic t, input logic mp);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_ghr        = g;
    bus.upd_taken      = t;
    bus.upd_mispredict = mp;
  endtask

  task automatic predict(input logic [31:0] pc, input logic [1:0] m);
    drive_pred(pc, m);
    tick();
  endtask

  task automatic update(input logic [31:0] pc, input logic [3:0] g, input logic t, input logic mp);
    drive_upd(pc, g, t, mp);
    tick();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_init(n);
    check_eq("reinit_cycles", n, 16);
  endtask

  initial begin
    int         n;
    int         correct;
    logic       p;
    logic       act;
    logic       src;
    logic [3:0] g;

    reset_n            = 1'b0;
    mode               = 2'b00;
    bus.pred_valid     = 1'b0;
    bus.pred_pc        = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_ghr        = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;

    // reset state and sweep length
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_pred_ready", bus.pred_ready, 0);
    check_eq("rst_out_valid", bus.pred_out_valid, 0);
    check_eq("rst_pred_ghr", bus.pred_ghr, 0);
    reset_n = 1'b1;
    wait_init(n);
    check_eq("init_cycles", n, 16);
    check_eq("init_ready", bus.pred_ready, 1);

    predict(32'h0, 2'b00);
    check_eq("first_out_valid", bus.pred_out_valid, 1);
    check_eq("first_taken", bus.pred_taken, 0);
    check_eq("first_src", bus.pred_src, 0);
    check_eq("first_ghr", bus.pred_ghr, 4'b0000);
    tick();
    check_eq("out_valid_pulse", bus.pred_out_valid, 0);

    // bimodal training; both tables agree so chooser stays weak-bimodal
    for (int i = 0; i < 3; i++) update(32'h40, 4'b0000, 1'b1, 1'b0);
    predict(32'h40, 2'b00);
    check_eq("t2_m00_taken", bus.pred_taken, 1);
    check_eq("t2_m00_src", bus.pred_src, 0);
    predict(32'h40, 2'b10);
    check_eq("t2_m10_taken", bus.pred_taken, 1);
    check_eq("t2_m10_ghr", bus.pred_ghr, 4'b0001);
    predict(32'h40, 2'b01);
    check_eq("t2_m01_taken", bus.pred_taken, 0);
    check_eq("t2_m01_src", bus.pred_src, 1);
    check_eq("t2_m01_ghr", bus.pred_ghr, 4'b0011);
    predict(32'h40, 2'b11);
    check_eq("t2_m11_taken", bus.pred_taken, 0);
    check_eq("t2_m11_src", bus.pred_src, 0);
    check_eq("t2_m11_ghr", bus.pred_ghr, 4'b0110);

    // alternating branch learned by gshare, chooser migrates to gshare
    do_reset();
    correct = 0;
    src = 1'b0;
    for (int i = 0; i < 40; i++) begin
      act = (i % 2 == 0);
      predict(32'h80, 2'b00);
      p   = bus.pred_taken;
      g   = bus.pred_ghr;
      src = bus.pred_src;
      if (i >= 32 && p == act) correct++;
      update(32'h80, g, act, p != act);
    end
    check_eq("t3_last8_correct", correct, 8);
    check_eq("t3_src_gshare", src, 1);

    // saturation at both ends of the bimodal counter
    for (int i = 0; i < 3; i++) update(32'h44, 4'b0000, 1'b0, 1'b0);
    update(32'h44, 4'b0000, 1'b1, 1'b0);
    predict(32'h44, 2'b10);
    check_eq("t5_sat_low", bus.pred_taken, 0);
    for (int i = 0; i < 4; i++) update(32'h48, 4'b0000, 1'b1, 1'b0);
    update(32'h48, 4'b0000, 1'b0, 1'b0);
    predict(32'h48, 2'b10);
    check_eq("t5_sat_high", bus.pred_taken, 1);

    // speculative shift and same-edge mispredict repair
    do_reset();
    update(32'h10, 4'b0000, 1'b1, 1'b0);
    update(32'h10, 4'b0000, 1'b1, 1'b0);
    update(32'h3c, 4'b0010, 1'b1, 1'b1);
    predict(32'h10, 2'b10);
    check_eq("t4_taken", bus.pred_taken, 1);
    check_eq("t4_pred_ghr", bus.pred_ghr, 4'b0101);
    predict(32'h10, 2'b11);
    check_eq("t4_shifted_ghr", bus.pred_ghr, 4'b1011);
    drive_pred(32'h10, 2'b10);
    drive_upd(32'h20, 4'b0011, 1'b1, 1'b1);
    tick();
    check_eq("t4_same_edge_valid", bus.pred_out_valid, 1);
    check_eq("t4_same_edge_taken", bus.pred_taken, 1);
    check_eq("t4_same_edge_ghr", bus.pred_ghr, 4'b0110);
    predict(32'h10, 2'b11);
    check_eq("t4_repaired_ghr", bus.pred_ghr, 4'b0111);

    // asynchronous reset mid-run, then tables are back to their swept defaults
    predict(32'h10, 2'b10);
    check_eq("t6_pre_valid", bus.pred_out_valid, 1);
    check_eq("t6_pre_taken", bus.pred_taken, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_valid", bus.pred_out_valid, 0);
    check_eq("t6_async_taken", bus.pred_taken, 0);
    check_eq("t6_async_ghr", bus.pred_ghr, 0);
    check_eq("t6_async_init_done", init_done, 0);
    check_eq("t6_async_ready", bus.pred_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_init(n);
    check_eq("t6_reinit_cycles", n, 16);
    predict(32'h10, 2'b10);
    check_eq("t6_bim_reswept", bus.pred_taken, 0);
    predict(32'h40, 2'b10);
    check_eq("t6_bim0_reswept", bus.pred_taken, 0);
    predict(32'h10, 2'b00);
    check_eq("t6_cho_reswept", bus.pred_src, 0);
    predict(32'h3c, 2'b01);
    check_eq("t6_gsh_reswept", bus.pred_taken, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
